// File: rtl/stream_permutation.sv
// Ping-pong frame buffer that reorders each SIZE-element frame through a
// selectable permutation table. Optional zero-fill flag: STREAM_PERM_ZERO_FILL_EN.
module stream_permutation #(
  parameter  int SIZE     = 257,
  parameter  int WIDTH    = 32,
  parameter  int NUM_PERM = 3,
  localparam int SEL_W    = (NUM_PERM > 1) ? $clog2(NUM_PERM) : 1,
  localparam int IDX_W    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             tbl_wr_en,
  input  logic [SEL_W-1:0] tbl_wr_sel,
  input  logic [IDX_W-1:0] tbl_wr_addr,
  input  logic [IDX_W:0]   tbl_wr_data,
  output logic             idle
);

`ifdef STREAM_PERM_ZERO_FILL_EN
  localparam int TBL_W = IDX_W + 1;
`else
  localparam int TBL_W = IDX_W;
`endif

  logic [WIDTH-1:0] bank [2][SIZE];
  logic [TBL_W-1:0] tbl  [NUM_PERM][SIZE];

  logic [1:0]       full;
  logic [SEL_W-1:0] sel_q [2];
  logic             wr_bank, rd_bank;
  logic [IDX_W-1:0] wr_cnt, rd_cnt;

  logic             accept, load, wr_last, rd_last;
  logic [SEL_W-1:0] sel_in, rd_sel;
  logic [TBL_W-1:0] entry;
  logic [IDX_W-1:0] src;
  logic             zero;
  logic [WIDTH-1:0] rd_word;

  assign in_ready = !full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign wr_last  = (wr_cnt == IDX_W'(SIZE - 1));
  assign rd_last  = (rd_cnt == IDX_W'(SIZE - 1));
  assign load     = (!out_valid || out_ready) && full[rd_bank];
  assign idle     = !full[0] && !full[1] && !out_valid;
  assign rd_sel   = sel_q[rd_bank];
  // Out-of-range selects fall back to table 0.
  assign sel_in   = ({1'b0, in_sel} < (SEL_W + 1)'(NUM_PERM)) ? in_sel : '0;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    entry   = tbl[rd_sel][rd_cnt];
    src     = entry[IDX_W-1:0];
    zero    = !({1'b0, src} < (IDX_W + 1)'(SIZE));
`ifdef STREAM_PERM_ZERO_FILL_EN
    zero    = zero || entry[IDX_W];
`endif
    rd_word = '0;
    if (!zero) rd_word = bank[rd_bank][src];
  end

  // NOTE: the frame banks and tables are storage arrays with no reset; flags and counters qualify them.
  always_ff @(posedge clk) begin
    if (accept) bank[wr_bank][wr_cnt] <= in_data;
    if (tbl_wr_en && ({1'b0, tbl_wr_sel} < (SEL_W + 1)'(NUM_PERM))
        && ({1'b0, tbl_wr_addr} < (IDX_W + 1)'(SIZE)))
      tbl[tbl_wr_sel][tbl_wr_addr] <= tbl_wr_data[TBL_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      sel_q[0]  <= '0;
      sel_q[1]  <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        if (wr_cnt == '0) sel_q[wr_bank] <= sel_in;
        if (wr_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      // A filling bank is never the full read bank, so these flag writes never collide.
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= rd_word;
        out_last  <= rd_last;
        if (rd_last) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
          rd_cnt        <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
